// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Imported by the interface, the match unit and the controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    MEM_WAIT
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] NO_STALL = 2'd0;
  localparam logic [1:0] STALL_1  = 2'd1;
  localparam logic [1:0] STALL_2  = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the ID/EX/MEM datapath and the hazard sequencer.
// slave = the sequencer, master = whoever drives the datapath side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_branch;
  logic             id_branch_taken;
  logic             id_jump;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       ex_dst;
  logic             mem_access;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_bubble;
  logic             dmem_req;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output id_branch, id_branch_taken, id_jump,
    output ex_regwrite, ex_memread, ex_dst,
    output mem_access, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en,
    input  ifid_flush, idex_flush, memwb_bubble,
    input  dmem_req, mem_err, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  id_branch, id_branch_taken, id_jump,
    input  ex_regwrite, ex_memread, ex_dst,
    input  mem_access, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en,
    output ifid_flush, idex_flush, memwb_bubble,
    output dmem_req, mem_err, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Register-dependency check between the ID instruction and the EX result.
// Returns how many bubbles ID must wait before its operands are usable.
module hazard_match
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_branch,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] ex_dst,
  output logic [1:0] need
);

  logic match;

  assign match = (ex_dst != REG_ZERO) &&
                 ((ex_dst == id_rs) ||
                  (id_uses_rt && ex_dst == id_rt));

  // Branches compare in ID, so even an ALU result is one cycle late.
  always_comb begin
    need = NO_STALL;
    if (match) begin
      if (id_branch && ex_memread)
        need = STALL_2;
      else if (id_branch && ex_regwrite)
        need = STALL_1;
      else if (!id_branch && ex_memread)
        need = STALL_1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: data stalls, branch squash, dmem freeze.
// Also counts cycles in which the PC was held.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam bit HAS_TO = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [1:0]       stall_left;
  logic             ret_stall;
  logic [TO_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] stall_cycles;

  logic [1:0] need;
  logic       in_wait;
  logic       stall_mode;
  logic       req;
  logic       timeout;
  logic       freeze;
  logic       data_stall;
  logic       ctrl_flush;
  logic       pc_hold;

  hazard_match u_match (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .id_branch   (bus.id_branch),
    .ex_regwrite (bus.ex_regwrite),
    .ex_memread  (bus.ex_memread),
    .ex_dst      (bus.ex_dst),
    .need        (need)
  );

  // The completion cycle of a wait behaves as the state it returns to.
  assign in_wait    = (state == MEM_WAIT);
  assign stall_mode = (state == STALL) ||
                      (in_wait && ret_stall);
  assign req        = in_wait || bus.mem_access;
  assign timeout    = HAS_TO && in_wait &&
                      !bus.dmem_ready &&
                      (wait_cnt == TO_LAST);
  assign freeze     = req && !bus.dmem_ready && !timeout;
  assign data_stall = stall_mode || (need != NO_STALL);
  assign ctrl_flush = bus.id_jump ||
                      (bus.id_branch && bus.id_branch_taken);
  assign pc_hold    = freeze || data_stall;

  assign bus.stall_cycles = stall_cycles;

  // Enables and flushes: freeze beats data stall beats squash.
  always_comb begin
    bus.pc_en        = 1'b1;
    bus.ifid_en      = 1'b1;
    bus.idex_en      = 1'b1;
    bus.exmem_en     = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.memwb_bubble = 1'b0;
    bus.dmem_req     = req && !rst;
    bus.mem_err      = timeout && !rst;
    if (rst) begin
      bus.pc_en        = 1'b0;
      bus.ifid_en      = 1'b0;
      bus.idex_en      = 1'b0;
      bus.exmem_en     = 1'b0;
      bus.ifid_flush   = 1'b1;
      bus.idex_flush   = 1'b1;
      bus.memwb_bubble = 1'b1;
    end else if (freeze) begin
      bus.pc_en        = 1'b0;
      bus.ifid_en      = 1'b0;
      bus.idex_en      = 1'b0;
      bus.exmem_en     = 1'b0;
      bus.memwb_bubble = 1'b1;
    end else if (data_stall) begin
      bus.pc_en      = 1'b0;
      bus.ifid_en    = 1'b0;
      bus.idex_flush = 1'b1;
    end else if (ctrl_flush) begin
      bus.ifid_flush = 1'b1;
    end
  end

  // Sequencer state, wait timer and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      stall_left   <= 2'd0;
      ret_stall    <= 1'b0;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      if (in_wait)
        wait_cnt <= wait_cnt + 1'b1;
      if (freeze) begin
        if (!in_wait) begin
          state     <= MEM_WAIT;
          wait_cnt  <= '0;
          ret_stall <= (state == STALL);
        end
      end else if (stall_mode) begin
        ret_stall  <= 1'b0;
        stall_left <= stall_left - 2'd1;
        state      <= (stall_left > 2'd1) ? STALL : RUN;
      end else begin
        ret_stall <= 1'b0;
        if (need == STALL_2) begin
          state      <= STALL;
          stall_left <= 2'd1;
        end else begin
          state <= RUN;
        end
      end
      if (pc_hold && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, corner sequences, random run.
// Random run is checked against a bubble-debt model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int CW   = 6;
  localparam int TO   = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       br;
    logic       tk;
    logic       jmp;
    logic       exrw;
    logic       exmr;
    logic [4:0] dst;
    logic       macc;
    logic       rdy;
  } in_t;

  // {pc,ifid,idex,exmem,ifid_fl,idex_fl,bubble,req,err}
  typedef logic [8:0] o_t;

  typedef struct {
    string nm;
    in_t   i;
    o_t    e;
  } vec_t;

  localparam o_t O_RUN  = 9'b1111_000_00;
  localparam o_t O_RUNR = 9'b1111_000_10;
  localparam o_t O_DST  = 9'b0011_010_00;
  localparam o_t O_DSTR = 9'b0011_010_10;
  localparam o_t O_FLS  = 9'b1111_100_00;
  localparam o_t O_FRZ  = 9'b0000_001_10;
  localparam o_t O_ERR  = 9'b1111_000_11;
  localparam o_t O_RST  = 9'b0000_111_00;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .CNT_W       (CW),
    .MEM_TIMEOUT (TO),
    .TO_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // model: outstanding bubble debt, wait status, counter
  int m_owed   = 0;
  int m_waited = 0;
  int m_cnt    = 0;
  bit m_wait   = 1'b0;

  function automatic in_t mk(int rs, int rt, bit urt, bit br,
                             bit tk, bit jmp, bit exrw,
                             bit exmr, int dst, bit macc,
                             bit rdy);
    in_t i;
    i.rs   = 5'(rs);
    i.rt   = 5'(rt);
    i.urt  = urt;
    i.br   = br;
    i.tk   = tk;
    i.jmp  = jmp;
    i.exrw = exrw;
    i.exmr = exmr;
    i.dst  = 5'(dst);
    i.macc = macc;
    i.rdy  = rdy;
    return i;
  endfunction

  function automatic int need_of(in_t i);
    bit hit;
    hit = (i.dst != 0) &&
          (i.dst == i.rs || (i.urt && i.dst == i.rt));
    if (!hit) return 0;
    if (i.br) return i.exmr ? 2 : (i.exrw ? 1 : 0);
    return i.exmr ? 1 : 0;
  endfunction

  function automatic o_t mdl_out(in_t i, bit r);
    bit req;
    bit to;
    bit frz;
    o_t o;
    if (r) return O_RST;
    req = m_wait || i.macc;
    to  = m_wait && (m_waited == TO - 1) && !i.rdy;
    frz = req && !i.rdy && !to;
    o = {4'b1111, 3'b000, req, to};
    if (frz) begin
      o[8:5] = 4'b0000;
      o[2]   = 1'b1;
    end else if (m_owed > 0 || need_of(i) > 0) begin
      o[8:7] = 2'b00;
      o[3]   = 1'b1;
    end else if (i.jmp || (i.br && i.tk)) begin
      o[4] = 1'b1;
    end
    return o;
  endfunction

  function automatic void mdl_step(in_t i, bit r);
    o_t o;
    o = mdl_out(i, r);
    if (r) begin
      m_owed   = 0;
      m_waited = 0;
      m_cnt    = 0;
      m_wait   = 1'b0;
      return;
    end
    if (!o[8] && m_cnt < CMAX) m_cnt++;
    if (o[2]) begin
      m_waited = m_wait ? m_waited + 1 : 0;
      m_wait   = 1'b1;
    end else begin
      m_wait = 1'b0;
      if (m_owed > 0) m_owed--;
      else if (need_of(i) > 0) m_owed = need_of(i) - 1;
    end
  endfunction

  function automatic o_t act_o();
    return {bus.pc_en, bus.ifid_en, bus.idex_en,
            bus.exmem_en, bus.ifid_flush, bus.idex_flush,
            bus.memwb_bubble, bus.dmem_req, bus.mem_err};
  endfunction

  task automatic chk_o(string nm, o_t a, o_t e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: outputs got %b want %b", nm, a, e);
  endtask

  task automatic chk_n(string nm, int a, int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, a, e);
  endtask

  task automatic drive(in_t i, bit r);
    bus.id_rs           = i.rs;
    bus.id_rt           = i.rt;
    bus.id_uses_rt      = i.urt;
    bus.id_branch       = i.br;
    bus.id_branch_taken = i.tk;
    bus.id_jump         = i.jmp;
    bus.ex_regwrite     = i.exrw;
    bus.ex_memread      = i.exmr;
    bus.ex_dst          = i.dst;
    bus.mem_access      = i.macc;
    bus.dmem_ready      = i.rdy;
    rst                 = r;
  endtask

  task automatic apply(in_t i, bit r, o_t e, string nm);
    @(negedge clk);
    drive(i, r);
    #1;
    chk_o(nm, act_o(), e);
    chk_n({nm, "_cnt"}, int'(bus.stall_cycles), m_cnt);
    mdl_step(i, r);
  endtask

  vec_t tbl[$];
  in_t  idle;
  in_t  bal;
  in_t  bwait;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(idle, 1'b1);

    tbl.push_back('{"no_haz",
      mk(1, 2, 1, 0, 0, 0, 1, 1, 3, 0, 1), O_RUN});
    tbl.push_back('{"lu_rs",
      mk(2, 5, 0, 0, 0, 0, 1, 1, 2, 0, 1), O_DST});
    tbl.push_back('{"lu_rt",
      mk(4, 2, 1, 0, 0, 0, 1, 1, 2, 0, 1), O_DST});
    tbl.push_back('{"rt_unused",
      mk(4, 2, 0, 0, 0, 0, 1, 1, 2, 0, 1), O_RUN});
    tbl.push_back('{"dst_zero",
      mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1), O_RUN});
    tbl.push_back('{"alu_fwd",
      mk(2, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1), O_RUN});
    tbl.push_back('{"br_alu",
      mk(3, 0, 1, 1, 0, 0, 1, 0, 3, 0, 1), O_DST});
    tbl.push_back('{"br_alu_tk",
      mk(3, 0, 1, 1, 1, 0, 1, 0, 3, 0, 1), O_DST});
    tbl.push_back('{"br_load",
      mk(0, 3, 1, 1, 1, 0, 1, 1, 3, 0, 1), O_DST});
    tbl.push_back('{"jump",
      mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), O_FLS});
    tbl.push_back('{"br_taken",
      mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 1), O_FLS});
    tbl.push_back('{"br_not_tk",
      mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1), O_RUN});
    tbl.push_back('{"tk_no_br",
      mk(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1), O_RUN});
    tbl.push_back('{"mem_0wait",
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_RUNR});
    tbl.push_back('{"mem_frz",
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_FRZ});
    tbl.push_back('{"frz_ov_stall",
      mk(2, 0, 0, 0, 0, 0, 1, 1, 2, 1, 0), O_FRZ});
    tbl.push_back('{"frz_ov_flush",
      mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), O_FRZ});
    tbl.push_back('{"stall_req",
      mk(2, 5, 0, 0, 0, 0, 1, 1, 2, 1, 1), O_DSTR});
    tbl.push_back('{"rdy_no_req",
      mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_RUN});

    foreach (tbl[k]) begin
      apply(idle, 1'b1, O_RST, "tbl_rst");
      apply(tbl[k].i, 1'b0, tbl[k].e, tbl[k].nm);
    end

    // load-use: one bubble, then the add proceeds
    apply(idle, 1'b1, O_RST, "rst");
    apply(mk(2, 0, 0, 0, 0, 0, 1, 1, 2, 0, 1), 1'b0,
          O_DST, "lu_s1");
    apply(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0,
          O_RUN, "lu_go");
    chk_n("lu_total", int'(bus.stall_cycles), 1);

    // branch after load, taken: two bubbles then squash
    bal   = mk(3, 0, 1, 1, 1, 0, 1, 1, 3, 0, 1);
    bwait = mk(3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    apply(idle, 1'b1, O_RST, "rst");
    apply(bal, 1'b0, O_DST, "bal_s1");
    apply(bwait, 1'b0, O_DST, "bal_s2");
    apply(bwait, 1'b0, O_FLS, "bal_flush");
    chk_n("bal_total", int'(bus.stall_cycles), 2);
    apply(idle, 1'b0, O_RUN, "bal_after");

    // four not-ready cycles then completion
    apply(idle, 1'b1, O_RST, "rst");
    for (int k = 0; k < 4; k++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0,
            O_FRZ, "mw_frz");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0,
          O_RUNR, "mw_done");
    apply(idle, 1'b0, O_RUN, "mw_after");
    chk_n("mw_total", int'(bus.stall_cycles), 4);

    // freeze lands on the second bubble of branch-after-load
    apply(idle, 1'b1, O_RST, "rst");
    apply(bal, 1'b0, O_DST, "fs_s1");
    apply(mk(3, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0), 1'b0,
          O_FRZ, "fs_frz1");
    apply(mk(3, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0), 1'b0,
          O_FRZ, "fs_frz2");
    apply(mk(3, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1), 1'b0,
          O_DSTR, "fs_s2");
    apply(bwait, 1'b0, O_FLS, "fs_flush");
    chk_n("fs_total", int'(bus.stall_cycles), 4);

    // timeout: error on the eighth wait cycle
    apply(idle, 1'b1, O_RST, "rst");
    for (int k = 0; k < 8; k++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0,
            O_FRZ, "to_frz");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0,
          O_ERR, "to_err");
    apply(idle, 1'b0, O_RUN, "to_after");
    chk_n("to_total", int'(bus.stall_cycles), 8);

    // reset on what would be the timeout cycle, with a bubble owed
    apply(idle, 1'b1, O_RST, "rst");
    apply(bal, 1'b0, O_DST, "rw_s1");
    for (int k = 0; k < 8; k++)
      apply(mk(3, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0), 1'b0,
            O_FRZ, "rw_frz");
    apply(mk(3, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0), 1'b1,
          O_RST, "rw_rst");
    apply(bwait, 1'b0, O_FLS, "rw_clear");
    chk_n("rw_total", int'(bus.stall_cycles), 0);

    // random traffic against the model
    begin
      int slow;
      slow = 0;
      for (int c = 0; c < 3000; c++) begin
        in_t i;
        bit  r;
        i.rs   = 5'($urandom_range(0, 3));
        i.rt   = 5'($urandom_range(0, 3));
        i.urt  = 1'($urandom_range(0, 1));
        i.br   = ($urandom_range(0, 3) == 0);
        i.tk   = 1'($urandom_range(0, 1));
        i.jmp  = !i.br && ($urandom_range(0, 7) == 0);
        i.exmr = ($urandom_range(0, 2) == 0);
        i.exrw = i.exmr || ($urandom_range(0, 1) == 1);
        i.dst  = 5'($urandom_range(0, 3));
        i.macc = ($urandom_range(0, 2) == 0);
        if (slow == 0 && $urandom_range(0, 99) < 3)
          slow = $urandom_range(1, 12);
        i.rdy = (slow > 0) ? 1'b0 :
                ($urandom_range(0, 9) < 7);
        if (slow > 0) slow--;
        r = ($urandom_range(0, 299) == 0);
        apply(i, r, mdl_out(i, r), "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
